hnf_txreq: RTL

- Downstream TXREQ link-layer transmitter of the home node.
- Accepts ReadNoSnp request flits from the SLC stage (read_no_snp / read_no_snp_v) and buffers them in a small FIFO.
- Launches buffered flits onto the CHI TXREQ channel (txreqflit/txreqflitv/txreqflitpend) under L-credit flow control driven by txreqlcrdv.
- Sits between the SLC miss path and the SN-side REQ link.

---
 rtl/hnf_txreq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hnf_txreq.sv
// Home-node TXREQ link transmitter: buffers ReadNoSnp flits and launches them under CHI L-credit flow control.
// Define HNF_TXREQ_CRD_RETURN_EN to add link deactivation (drain queue, then hand all credits back).
module hnf_txreq #(
   parameter int DEPTH   = 4,
   parameter int CRD_MAX = 15,
   parameter int DATA_W  = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        read_no_snp,
   input  logic                     read_no_snp_v,
   output logic                     read_no_snp_rdy,
   output logic [DATA_W-1:0]        txreqflit,
   output logic                     txreqflitv,
   output logic                     txreqflitpend,
   input  logic                     txreqlcrdv,
   output logic [3:0]               crd_cnt,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic                     crd_ovf_err
`ifdef HNF_TXREQ_CRD_RETURN_EN
   ,
   input  logic                     link_deact_req,
   output logic                     link_deact_done
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              pop;
   logic              ret_flit;
   logic              launch;
   logic              enq;
   logic              fifo_open;

   // Credit count update, clamped at the link maximum.
   function automatic logic [3:0] crd_next(input logic [3:0] c, input logic inc, input logic dec);
      logic [4:0] s;
      s = {1'b0, c} + {4'd0, inc} - {4'd0, dec};
      if (s > 5'(CRD_MAX))
         s = 5'(CRD_MAX);
      return s[3:0];
   endfunction

`ifdef HNF_TXREQ_CRD_RETURN_EN
   typedef enum logic [1:0] {RUN, DRAIN, RETURN, DONE} link_state_t;
   link_state_t lstate;

   always_ff @(posedge clock) begin
      if (reset) begin
         lstate          <= RUN;
         link_deact_done <= 1'b0;
      end else begin
         case (lstate)
            RUN:     if (link_deact_req) lstate <= DRAIN;
            DRAIN:   if (fifo_cnt == '0) lstate <= RETURN;
            RETURN:  if (crd_cnt == 4'd0) begin
                        lstate          <= DONE;
                        link_deact_done <= 1'b1;
                     end
            DONE:    if (!link_deact_req) begin
                        lstate          <= RUN;
                        link_deact_done <= 1'b0;
                     end
            default: lstate <= RUN;
         endcase
      end
   end

   always_comb begin
      ret_flit  = (lstate == RETURN) && (crd_cnt != 4'd0);
      fifo_open = (lstate == RUN);
   end
`else
   always_comb begin
      ret_flit  = 1'b0;
      fifo_open = 1'b1;
   end
`endif

   always_comb begin
      pop             = (fifo_cnt != '0) && (crd_cnt != 4'd0);
      launch          = pop || ret_flit;
      read_no_snp_rdy = !reset && fifo_open && (fifo_cnt != (AW+1)'(DEPTH));
      enq             = read_no_snp_v && read_no_snp_rdy;
      txreqflitpend   = (fifo_cnt != '0);
   end

   // Storage carries no reset; occupancy and pointers define validity.
   always_ff @(posedge clock) begin
      if (enq)
         mem[wr_ptr] <= read_no_snp;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_cnt    <= '0;
         crd_cnt     <= 4'd0;
         crd_ovf_err <= 1'b0;
         txreqflitv  <= 1'b0;
         txreqflit   <= '0;
      end else begin
         if (enq)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt + (AW+1)'(enq) - (AW+1)'(pop);
         crd_cnt  <= crd_next(crd_cnt, txreqlcrdv, launch);
         if (txreqlcrdv && (crd_cnt == 4'(CRD_MAX)) && !launch)
            crd_ovf_err <= 1'b1;
         // Launch stage: flit appears on the channel the cycle after the pop.
         txreqflitv <= launch;
         if (pop)
            txreqflit <= mem[rd_ptr];
         else if (ret_flit)
            txreqflit <= '0;
      end
   end

endmodule
